// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: converts the pod model's fixed-point position
// into a rate-limited, phase-continuous A/B step stream for the flight computer.
`timescale 1ns/1ps
module quad_encoder_emulator #(
  parameter int COUNT_SHIFT = 16,
  parameter int MIN_PERIOD  = 2,
  parameter int MAX_BACKLOG = 1024,
  localparam int W = 64 - COUNT_SHIFT
) (
  input  logic         clk_200khz,
  input  logic         reset,
  input  logic [63:0]  position,
  input  logic         enable,
  input  logic         preset,
  output logic         enc_a,
  output logic         enc_b,
  output logic [W-1:0] emitted_count,
  output logic         busy,
  output logic         lag_error
);

  localparam int            HW          = $clog2(MIN_PERIOD + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(MIN_PERIOD - 1);
  localparam logic [W:0]    BACKLOG_LIM = (W+1)'(MAX_BACKLOG);

  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  emitted_q, emitted_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic [1:0]    phase_q, phase_d;
  logic          lag_q, lag_d;

  logic signed [W:0] diff;
  logic [W:0]        diff_mag;
  logic              step;

  always_comb begin
    target_d  = W'($signed(position) >>> COUNT_SHIFT);
    // One extra bit keeps the sign of the true difference even when the
    // count wraps, so the direction is always correct.
    diff      = $signed({target_q[W-1], target_q}) - $signed({emitted_q[W-1], emitted_q});
    diff_mag  = diff[W] ? -diff : diff;
    step      = enable && (diff != '0) && (holdoff_q == '0) && !preset;

    phase_d   = phase_q;
    emitted_d = emitted_q;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;

    if (preset) begin
      emitted_d = target_q;
      holdoff_d = '0;
    end else if (step) begin
      holdoff_d = HOLD_RELOAD;
      if (diff[W]) begin
        // Reverse walk: 00 -> 01 -> 11 -> 10 -> 00.
        phase_d   = {phase_q[0], ~phase_q[1]};
        emitted_d = emitted_q - W'(1);
      end else begin
        // Forward walk (A leads B): 00 -> 10 -> 11 -> 01 -> 00.
        phase_d   = {~phase_q[0], phase_q[1]};
        emitted_d = emitted_q + W'(1);
      end
    end

    lag_d = lag_q || (diff_mag > BACKLOG_LIM);
  end

  always_ff @(posedge clk_200khz) begin
    if (reset) begin
      target_q  <= '0;
      emitted_q <= '0;
      holdoff_q <= '0;
      phase_q   <= 2'b00;
      lag_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      emitted_q <= emitted_d;
      holdoff_q <= holdoff_d;
      phase_q   <= phase_d;
      lag_q     <= lag_d;
    end
  end

  assign enc_a         = phase_q[1];
  assign enc_b         = phase_q[0];
  assign emitted_count = emitted_q;
  assign busy          = (diff != '0);
  assign lag_error     = lag_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: two instances (MIN_PERIOD 2 and 4)
// share one stimulus stream; every expectation is hand-computed.
`timescale 1ns/1ps
module tb_quad_encoder_emulator;
  localparam int W = 48;

  // Clock / reset block
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] position;
  logic        enable;
  logic        preset;

  always #5 clk = ~clk;

  logic         a2, b2, busy2, lag2;
  logic [W-1:0] cnt2;
  logic         a4, b4, busy4, lag4;
  logic [W-1:0] cnt4;

  quad_encoder_emulator #(.COUNT_SHIFT(16), .MIN_PERIOD(2), .MAX_BACKLOG(1024)) dut (
    .clk_200khz(clk), .reset(reset), .position(position), .enable(enable), .preset(preset),
    .enc_a(a2), .enc_b(b2), .emitted_count(cnt2), .busy(busy2), .lag_error(lag2)
  );

  quad_encoder_emulator #(.COUNT_SHIFT(16), .MIN_PERIOD(4), .MAX_BACKLOG(1024)) dut4 (
    .clk_200khz(clk), .reset(reset), .position(position), .enable(enable), .preset(preset),
    .enc_a(a4), .enc_b(b4), .emitted_count(cnt4), .busy(busy4), .lag_error(lag4)
  );

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    preset   = 1'b0;
    position = '0;
    tick();
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] e;
    logic [1:0] prev[2];
    logic [1:0] cur[2];
    int edges[2], first[2], last[2], bad[2], bad_sp[2];
    int spacing[2];
    spacing = '{2, 4};

    @(negedge clk);
    do_reset();
    check("rst_ab",   64'({a2, b2}), 64'd0);
    check("rst_cnt",  64'(cnt2),     64'd0);
    check("rst_busy", 64'(busy2),    64'd0);
    check("rst_lag",  64'(lag2),     64'd0);

    // Forward 3 counts at MIN_PERIOD 2
    enable   = 1'b1;
    position = 64'(3) << 16;
    exp_q = '{{2'b00, 8'd0}, {2'b10, 8'd1}, {2'b10, 8'd1},
              {2'b11, 8'd2}, {2'b11, 8'd2}, {2'b01, 8'd3}};
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("fwd_ab_k%0d", k),  64'({a2, b2}), 64'(e[9:8]));
      check($sformatf("fwd_cnt_k%0d", k), 64'(cnt2),     64'(e[7:0]));
    end
    check("fwd_busy_end", 64'(busy2), 64'd0);

    // Back to zero
    position = '0;
    exp_q = '{{2'b01, 8'd3}, {2'b11, 8'd2}, {2'b11, 8'd2},
              {2'b10, 8'd1}, {2'b10, 8'd1}, {2'b00, 8'd0}};
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("rev_ab_k%0d", k),  64'({a2, b2}), 64'(e[9:8]));
      check($sformatf("rev_cnt_k%0d", k), 64'(cnt2),     64'(e[7:0]));
    end

    repeat (20) tick();
    check("idle4_ab",  64'({a4, b4}), 64'd0);
    check("idle4_cnt", 64'(cnt4),     64'd0);

    // +100 counts: edge spacing and phase legality on both instances
    position = 64'(100) << 16;
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0; first[i] = 0; last[i] = 0; bad[i] = 0; bad_sp[i] = 0;
    end
    prev[0] = {a2, b2};
    prev[1] = {a4, b4};
    for (int k = 1; k <= 420; k++) begin
      tick();
      cur[0] = {a2, b2};
      cur[1] = {a4, b4};
      for (int i = 0; i < 2; i++) begin
        if (cur[i] != prev[i]) begin
          edges[i]++;
          if (first[i] == 0) first[i] = k;
          if (last[i] != 0 && (k - last[i]) != spacing[i]) bad_sp[i]++;
          if (cur[i] != fwd_of(prev[i])) bad[i]++;
          last[i] = k;
        end
        prev[i] = cur[i];
      end
    end
    check("p2_edges",   64'(edges[0]),  64'd100);
    check("p2_last",    64'(last[0]),   64'd200);
    check("p2_spacing", 64'(bad_sp[0]), 64'd0);
    check("p2_phase",   64'(bad[0]),    64'd0);
    check("p2_cnt",     64'(cnt2),      64'd100);
    check("p4_edges",   64'(edges[1]),  64'd100);
    check("p4_first",   64'(first[1]),  64'd2);
    check("p4_last",    64'(last[1]),   64'd398);
    check("p4_spacing", 64'(bad_sp[1]), 64'd0);
    check("p4_phase",   64'(bad[1]),    64'd0);
    check("p4_cnt",     64'(cnt4),      64'd100);
    check("p4_busy",    64'(busy4),     64'd0);

    // +2000 counts: backlog overflow
    position = 64'(2100) << 16;
    tick();
    check("lag_not_yet", 64'(lag2), 64'd0);
    tick();
    check("lag_set2", 64'(lag2), 64'd1);
    check("lag_set4", 64'(lag4), 64'd1);
    for (int k = 0; k < 5000 && cnt2 != W'(2100); k++) tick();
    check("lag_reach",  64'(cnt2),  64'd2100);
    check("lag_sticky", 64'(lag2),  64'd1);
    check("lag_busy",   64'(busy2), 64'd0);
    check("lag4_busy",  64'(busy4), 64'd1);

    // Reset while dut4 is still stepping
    reset = 1'b1;
    tick();
    check("midrst_ab4",   64'({a4, b4}), 64'd0);
    check("midrst_cnt4",  64'(cnt4),     64'd0);
    check("midrst_lag4",  64'(lag4),     64'd0);
    check("midrst_lag2",  64'(lag2),     64'd0);
    check("midrst_busy4", 64'(busy4),    64'd0);
    do_reset();

    // Preset while disabled
    position = 64'(50) << 16;
    tick();
    check("pre_busy", 64'(busy2), 64'd1);
    tick();
    check("dis_hold_ab",  64'({a2, b2}), 64'd0);
    check("dis_hold_cnt", 64'(cnt2),     64'd0);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check("preset_cnt",  64'(cnt2),     64'd50);
    check("preset_ab",   64'({a2, b2}), 64'd0);
    check("preset_busy", 64'(busy2),    64'd0);
    enable = 1'b1;
    repeat (5) tick();
    check("post_en_ab",   64'({a2, b2}), 64'd0);
    check("post_en_cnt",  64'(cnt2),     64'd50);
    check("post_en_busy", 64'(busy2),    64'd0);

    // Preset beats a simultaneous step
    position = 64'(53) << 16;
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check("prio_cnt", 64'(cnt2),     64'd53);
    check("prio_ab",  64'({a2, b2}), 64'd0);

    // Enable dropping mid-sequence
    position = 64'(57) << 16;
    tick();
    tick();
    check("en_step1_ab",  64'({a2, b2}), 64'h2);
    check("en_step1_cnt", 64'(cnt2),     64'd54);
    enable = 1'b0;
    repeat (3) tick();
    check("en_hold_ab",  64'({a2, b2}), 64'h2);
    check("en_hold_cnt", 64'(cnt2),     64'd54);
    enable = 1'b1;
    tick();
    check("en_resume_ab",  64'({a2, b2}), 64'h3);
    check("en_resume_cnt", 64'(cnt2),     64'd55);

    // Backlog threshold is strictly greater-than
    do_reset();
    position = 64'(1024) << 16;
    repeat (3) tick();
    check("lag_eq_limit", 64'(lag2), 64'd0);
    position = 64'(1025) << 16;
    tick();
    tick();
    check("lag_over_limit", 64'(lag2), 64'd1);

    // Half-count increments: one edge per 0x10000 crossing
    do_reset();
    enable  = 1'b1;
    prev[0] = {a2, b2};
    edges[0] = 0;
    bad[0]   = 0;
    for (int k = 0; k < 50; k++) begin
      if (k < 40) position = position + 64'h8000;
      tick();
      cur[0] = {a2, b2};
      if (cur[0] != prev[0]) begin
        edges[0]++;
        if (cur[0] != fwd_of(prev[0])) bad[0]++;
      end
      prev[0] = cur[0];
    end
    check("half_edges", 64'(edges[0]), 64'd20);
    check("half_phase", 64'(bad[0]),   64'd0);
    check("half_cnt",   64'(cnt2),     64'd20);
    check("half_ab",    64'({a2, b2}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emulator.md
# quad_encoder_emulator

Converts the pod model's 64-bit position into a rate-limited quadrature A/B pulse train, emulating a wheel/track encoder as seen by the flight computer under test. It is the sensor-side consumer of the pod dynamics: the model integrates motion, and this block reports it back to the flight controller. It runs in the same clock domain as the pod model.

## Interface

Parameters:
- COUNT_SHIFT, 16: position LSBs per encoder count. Count width W = 64 - COUNT_SHIFT.
- MIN_PERIOD, 2: minimum clock cycles between successive A/B edges. Must be ≥ 1.
- MAX_BACKLOG, 1024: maximum |target - emitted| in counts before lag_error is flagged.

Ports:
- clk_200khz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- position  in  64  signed two's-complement position from the pod model.
- enable  in  1  when 1, the block may emit steps; when 0, A/B and emitted_count hold.
- preset  in  1  single-cycle pulse: sets emitted_count to the current target without emitting edges.
- enc_a  out  1  quadrature channel A (registered).
- enc_b  out  1  quadrature channel B (registered).
- emitted_count  out  W  signed count of net steps emitted.
- busy  out  1  1 while target_r != emitted_count.
- lag_error  out  1  sticky backlog-overflow flag.

## Operation

- Input register: target_r <= position >>> COUNT_SHIFT, an arithmetic shift truncated to W bits, every cycle including while enable = 0.
- diff = target_r - emitted_count, computed in W+1 bits signed so it cannot overflow.
- Holdoff counter: reloads to MIN_PERIOD-1 on every step and otherwise decrements to 0 and saturates. It counts regardless of enable.
- Step condition: enable = 1, diff != 0, holdoff = 0, and preset = 0.
- Forward step (diff > 0): phase advances 00→10→11→01→00, where phase is {A,B} and A leads B. emitted_count increments by 1.
- Reverse step (diff < 0): phase follows the same sequence backwards. emitted_count decrements by 1.
- At most one step per cycle. A/B never change by more than one bit per cycle.
- Preset has priority over stepping:
  - emitted_count <= target_r and holdoff <= 0.
  - phase and A/B are unchanged.
  - preset is honoured even when enable = 0.
- busy is combinational from registers: diff != 0.
- lag_error: set on the clock edge where |diff| > MAX_BACKLOG, evaluated on registered values. Only reset clears it. Stepping continues normally while it is set; the block never jumps.
- emitted_count wraps modulo 2^W. The diff arithmetic always takes the direction of the true signed difference.
- Reset values: enc_a = 0, enc_b = 0, phase = 00, emitted_count = 0, target_r = 0, holdoff = 0, busy = 0, lag_error = 0.
- Reset mid-run: A/B go to 00 on the next edge even if this is an illegal quadrature jump. This is accepted by design. After reset the block catches up from 0 unless preset is used.

## Timing

- A position change sampled at edge N is in target_r after edge N. The first resulting A/B edge appears after edge N+1, a latency of 2 cycles.
- Sustained rate: one edge per MIN_PERIOD cycles. With MIN_PERIOD = 1, one edge per cycle.
- Simultaneous preset and step condition: preset wins and no edge is emitted that cycle.
- Simultaneous reset and anything else: reset wins.
- enable falling mid-sequence: edges stop on the next cycle and resume with the correct phase continuity when enable returns.
- lag_error asserts one cycle after target_r first exceeds the backlog.

## Test plan

- Reset, enable = 1, position = 3<<16, MIN_PERIOD = 2 -> {A,B} = 10, 11, 01 on edges 2, 4 and 6 cycles after the position change. emitted_count ends at 3 and busy drops to 0.
- From the state above, position = 0 -> {A,B} = 11, 10, 00 at 2-cycle spacing. emitted_count ends at 0.
- MIN_PERIOD = 4, position step of +100 counts -> 100 edges, exactly 4 cycles apart. Last edge 2 + 99·4 cycles after the change. A/B are never both toggled in one cycle.
- MAX_BACKLOG = 1024, step of +2000 counts -> lag_error = 1 one cycle after target_r updates. It stays 1 after emitted_count reaches 2000, until reset.
- enable = 0, position = 50<<16, pulse preset -> emitted_count = 50 with no A/B change. Raising enable afterwards produces no edges and busy = 0.
- Position increments of 0x8000 per cycle -> an edge only when a 0x10000 boundary is crossed. Reset asserted mid-stepping -> the next cycle shows A/B = 00, emitted_count = 0 and lag_error = 0.
